// File: rtl/ps2_rx_if.sv
// Pop-side bus of the PS/2 receiver: FIFO head, empty flag, pop strobe and status.
// master = receiver (drives data/status), slave = consumer (drives rd).
interface ps2_rx_if;
  logic       rd;
  logic [9:0] dout;
  logic       empty;
  logic       err;
  logic       overflow;

  modport master (input rd, output dout, empty, err, overflow);
  modport slave  (output rd, input dout, empty, err, overflow);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: sync + de-glitch, 11-bit frame check, byte FIFO; PS2_RX_SCANDECODE_EN folds E0/F0 prefixes into dout[9:8].
// Latency FILTER+4 clk_sys from stop-bit fall to empty=0; no backpressure on the line, a push into a full FIFO is dropped and sets overflow.
module ps2_rx #(
  parameter int FILTER    = 8,
  parameter int TIMEOUT   = 4096,
  parameter int FIFO_BITS = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  ps2_rx_if.master   rx
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                 clk_s1, clk_s2, dat_s1, dat_s2;
  logic [7:0]           flt_cnt;
  logic                 clk_f, clk_f_d, fall_q;
  state_t               state, state_nxt;
  logic [2:0]           bit_cnt;
  logic [7:0]           shreg;
  logic                 par_bit;
  logic [TW-1:0]        tmo_cnt;
  logic                 shift_en, par_en, frame_ok, frame_bad, tmo_hit;
  logic                 err_q, ovf_q;
  logic                 pf_vld;
  logic [9:0]           pf_dat;
  logic [FIFO_BITS:0]   wptr, rptr;
  logic [9:0]           mem [DEPTH];
  logic                 empty_w, full_w, rd_ok, wr_ok, drop;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered clock follows the synchronised line only after FILTER agreeing samples.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      flt_cnt <= '0;
      clk_f   <= 1'b1;
      clk_f_d <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      clk_f_d <= clk_f;
      fall_q  <= clk_f_d & ~clk_f;
      if (clk_s2 != clk_f) begin
        if (flt_cnt == 8'(FILTER - 1)) begin
          clk_f   <= clk_s2;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + 8'd1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    tmo_hit   = (state != IDLE) && !fall_q && (tmo_cnt == TW'(TIMEOUT));
    case (state)
      IDLE: begin
        if (fall_q && !dat_s2) state_nxt = DATA;
      end
      DATA: begin
        if (fall_q) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (fall_q) begin
          par_en    = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (fall_q) begin
          if (dat_s2 && (^shreg ^ par_bit)) frame_ok  = 1'b1;
          else                              frame_bad = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (tmo_hit) state_nxt = IDLE;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= frame_bad | tmo_hit;
      if (state == IDLE) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {dat_s2, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_en) par_bit <= dat_s2;
      // Counts only mid-frame; saturates so a stalled line cannot wrap it.
      if (state == IDLE || fall_q)        tmo_cnt <= '0;
      else if (tmo_cnt != TW'(TIMEOUT))   tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

`ifdef PS2_RX_SCANDECODE_EN
  logic ext_f, rel_f;

  always_comb begin
    pf_vld = frame_ok && (shreg != 8'hE0) && (shreg != 8'hF0);
    pf_dat = {ext_f, rel_f, shreg};
  end

  // Prefix flags survive only until the byte they qualify is pushed or lost.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ext_f <= 1'b0;
      rel_f <= 1'b0;
    end else if (frame_bad || tmo_hit || drop) begin
      ext_f <= 1'b0;
      rel_f <= 1'b0;
    end else if (frame_ok) begin
      if (shreg == 8'hE0) begin
        ext_f <= 1'b1;
      end else if (shreg == 8'hF0) begin
        rel_f <= 1'b1;
      end else begin
        ext_f <= 1'b0;
        rel_f <= 1'b0;
      end
    end
  end
`else
  assign pf_vld = frame_ok;
  assign pf_dat = {2'b00, shreg};
`endif

  assign empty_w = (wptr == rptr);
  assign full_w  = (wptr[FIFO_BITS] != rptr[FIFO_BITS]) &&
                   (wptr[FIFO_BITS-1:0] == rptr[FIFO_BITS-1:0]);
  assign rd_ok   = rx.rd && !empty_w;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_ok   = pf_vld && (!full_w || rd_ok);
  assign drop    = pf_vld && full_w && !rd_ok;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_ok) wptr  <= wptr + 1'b1;
      if (rd_ok) rptr  <= rptr + 1'b1;
      if (drop)  ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_ok) mem[wptr[FIFO_BITS-1:0]] <= pf_dat;
  end

  assign rx.dout     = empty_w ? 10'd0 : mem[rptr[FIFO_BITS-1:0]];
  assign rx.empty    = empty_w;
  assign rx.err      = err_q;
  assign rx.overflow = ovf_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Randomised bench for ps2_rx: frames are bit-banged on ps2_clk/ps2_data and compared with a queue-based byte model.
module tb_ps2_rx;
  localparam int FILTER    = 8;
  localparam int TIMEOUT   = 4096;
  localparam int FIFO_BITS = 3;
  localparam int DEPTH     = 1 << FIFO_BITS;

  logic clk_sys  = 1'b0;
  logic reset_n  = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_rx_if bus();

  ps2_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .FIFO_BITS(FIFO_BITS)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx      (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_err = 0;
  int err_seen = 0;
  int exp_err = 0;
  logic [9:0] q[$];
  bit exp_ovf = 1'b0;
`ifdef PS2_RX_SCANDECODE_EN
  bit m_ext = 1'b0;
  bit m_rel = 1'b0;
`endif

  always @(negedge clk_sys) if (bus.err === 1'b1) err_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [9:0] v);
    if (q.size() < DEPTH) q.push_back(v);
    else begin
      exp_ovf = 1'b1;
`ifdef PS2_RX_SCANDECODE_EN
      m_ext = 1'b0;
      m_rel = 1'b0;
`endif
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit par, input bit stop);
    if (stop && ((^b) ^ par)) begin
`ifdef PS2_RX_SCANDECODE_EN
      if (b == 8'hE0)      m_ext = 1'b1;
      else if (b == 8'hF0) m_rel = 1'b1;
      else begin
        model_push({m_ext, m_rel, b});
        m_ext = 1'b0;
        m_rel = 1'b0;
      end
`else
      model_push({2'b00, b});
`endif
    end else begin
      exp_err++;
`ifdef PS2_RX_SCANDECODE_EN
      m_ext = 1'b0;
      m_rel = 1'b0;
`endif
    end
  endtask

  // nbits < 11 truncates the frame; rd_at > 0 pops k cycles after the stop-bit fall.
  task automatic send_frame(input logic [7:0] b, input bit par, input bit stop, input int hp,
                            input int nbits, input int rd_at, output int lat);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    lat = -1;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_sys);
      ps2_data = bits[i];
      repeat (hp) @(negedge clk_sys);
      ps2_clk = 1'b0;
      for (int k = 1; k <= hp; k++) begin
        @(negedge clk_sys);
        if (i == 10) begin
          if (lat < 0 && bus.empty === 1'b0) lat = k;
          if (rd_at > 0 && k == rd_at) begin
            check("coinc_head", bus.dout, q[0]);
            bus.rd = 1'b1;
            void'(q.pop_front());
          end
          if (rd_at > 0 && k == rd_at + 1) bus.rd = 1'b0;
        end
      end
      ps2_clk = 1'b1;
    end
    @(negedge clk_sys);
    ps2_data = 1'b1;
    repeat (hp) @(negedge clk_sys);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_err"}, err_seen, exp_err);
    check({tag, "_empty"}, bus.empty, (q.size() == 0));
    check({tag, "_ovf"}, bus.overflow, exp_ovf);
    if (q.size() > 0) check({tag, "_head"}, bus.dout, q[0]);
  endtask

  task automatic frame_chk(input logic [7:0] b, input bit par, input bit stop, input int hp,
                           input string tag);
    int lat;
    send_frame(b, par, stop, hp, 11, 0, lat);
    model_frame(b, par, stop);
    check_state(tag);
  endtask

  task automatic good_frame(input logic [7:0] b, input int hp, input string tag);
    frame_chk(b, ~^b, 1'b1, hp, tag);
  endtask

  task automatic pop_chk(input string tag);
    @(negedge clk_sys);
    check(tag, bus.dout, q[0]);
    bus.rd = 1'b1;
    void'(q.pop_front());
    @(negedge clk_sys);
    bus.rd = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) pop_chk(tag);
    @(negedge clk_sys);
    check({tag, "_empty"}, bus.empty, 1'b1);
    check({tag, "_dout0"}, bus.dout, 10'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    q.delete();
    exp_ovf = 1'b0;
`ifdef PS2_RX_SCANDECODE_EN
    m_ext = 1'b0;
    m_rel = 1'b0;
`endif
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] b;
    int hp, r;
    bit par, stop;

    bus.rd = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("rst_empty", bus.empty, 1'b1);
    check("rst_dout", bus.dout, 10'd0);
    check("rst_err", bus.err, 1'b0);
    check("rst_ovf", bus.overflow, 1'b0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);

    // Basic frame with latency measurement
    send_frame(8'h1C, 1'b0, 1'b1, 200, 11, 0, lat);
    model_frame(8'h1C, 1'b0, 1'b1);
    check("latency", lat, FILTER + 4);
    check_state("basic");
    drain("basic_pop");

    frame_chk(8'h1C, 1'b1, 1'b1, 40, "bad_par");
    frame_chk(8'h1C, 1'b0, 1'b0, 40, "bad_stop");

    good_frame(8'hE0, 30, "dec_e0");
    good_frame(8'hF0, 30, "dec_f0");
    good_frame(8'h75, 30, "dec_75");
    drain("dec_pop");

    for (int i = 1; i <= 9; i++) good_frame(8'(i), 30, "ovf_fill");
    drain("ovf_pop");

    // Push coinciding with pop on a full FIFO
    do_reset();
    check("rst2_ovf", bus.overflow, 1'b0);
    for (int i = 1; i <= DEPTH; i++) good_frame(8'(i), 30, "coinc_fill");
    send_frame(8'hA5, ~^8'hA5, 1'b1, 30, 11, FILTER + 3, lat);
    model_frame(8'hA5, ~^8'hA5, 1'b1);
    check_state("coinc");
    drain("coinc_pop");

    // Stalled frame: start + 4 data bits, then silence
    send_frame(8'h3C, 1'b0, 1'b1, 30, 5, 0, lat);
    check("tmo_early", err_seen, exp_err);
    repeat (TIMEOUT + 20) @(negedge clk_sys);
    exp_err++;
    check_state("tmo");
    good_frame(8'h5A, 30, "tmo_recover");
    drain("tmo_pop");

    // 3-cycle clock glitch with data held low
    @(negedge clk_sys);
    ps2_data = 1'b0;
    repeat (20) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk_sys);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk_sys);
    check("glitch_err", err_seen, exp_err);
    good_frame(8'h21, 30, "glitch_frame");
    drain("glitch_pop");

    // Reset after the 5th data bit, with an entry already queued
    good_frame(8'h11, 30, "pre_rst");
    send_frame(8'h77, ~^8'h77, 1'b1, 30, 6, 0, lat);
    do_reset();
    @(negedge clk_sys);
    check("midrst_empty", bus.empty, 1'b1);
    check("midrst_dout", bus.dout, 10'd0);
    good_frame(8'h33, 30, "post_rst");
    drain("post_rst_pop");

    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom);
      hp = $urandom_range(14, 40);
      r = $urandom_range(0, 7);
      par = (~^b) ^ (r == 0);
      stop = (r != 1);
      frame_chk(b, par, stop, hp, "rand");
      if ($urandom_range(0, 1) == 1 && q.size() > 0) pop_chk("rand_pop");
    end
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
